// File: rtl/shared_mem_arbiter.sv
// Shared data memory with a round-robin arbiter for CORE_COUNT cores.
// Each grant performs one access on a single-port memory, so the cores
// are serialized. A core sees a one-cycle ready pulse two cycles after
// its request is granted.
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   enable_M   - per-core 2-bit request code (01 LD, 10 ST, 00/11 none)
//   addr_M     - per-core word address (ADDR_SIZE bits per lane)
//   wr_data_M  - per-core store data (REG_SIZE bits per lane)
//   rd_data_M  - registered load word, replicated on every lane
//   ready_M    - per-core one-cycle completion pulse
module shared_mem_arbiter #(
   parameter int unsigned CORE_COUNT   = 4,
   parameter int unsigned REG_SIZE     = 8,
   parameter int unsigned CORE_ID_SIZE = 2,
   localparam int unsigned ADDR_SIZE   = CORE_ID_SIZE + REG_SIZE
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [2*CORE_COUNT-1:0]         enable_M,
   input  logic [ADDR_SIZE*CORE_COUNT-1:0] addr_M,
   input  logic [REG_SIZE*CORE_COUNT-1:0]  wr_data_M,
   output logic [REG_SIZE*CORE_COUNT-1:0]  rd_data_M,
   output logic [CORE_COUNT-1:0]           ready_M
);

   localparam int unsigned IDX_W     = $clog2(CORE_COUNT);
   localparam int unsigned MEM_DEPTH = 1 << ADDR_SIZE;
   localparam logic [1:0]  OP_LD     = 2'b01;
   localparam logic [1:0]  OP_ST     = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  grant;
   logic [IDX_W-1:0]      last;
   logic [IDX_W-1:0]      gnt_idx;
   logic [1:0]            op_r;
   logic [ADDR_SIZE-1:0]  addr_r;
   logic [REG_SIZE-1:0]   wdata_r;
   logic [REG_SIZE-1:0]   rd_data_r;
   logic [CORE_COUNT-1:0] ready_r;
   logic [CORE_COUNT-1:0] req_vld;
   logic                  win_vld;
   logic [IDX_W-1:0]      win_idx;
   logic [IDX_W-1:0]      cand;

   logic [REG_SIZE-1:0]   mem [MEM_DEPTH];

   // Valid request: exactly one of the two code bits set (01 or 10).
   always_comb begin
      req_vld = '0;
      for (int unsigned i = 0; i < CORE_COUNT; i++) begin
         req_vld[i] = ^enable_M[2*i +: 2];
      end
   end

   // Round-robin search starting at last+1. In RESP the core being answered
   // still shows its request, so it is skipped.
   always_comb begin
      win_vld = 1'b0;
      win_idx = last;
      cand    = '0;
      for (int unsigned k = 1; k <= CORE_COUNT; k++) begin
         cand = IDX_W'(32'(last) + k);
         if (!win_vld && req_vld[cand] && !(state == RESP && cand == gnt_idx)) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_vld) begin
               grant     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: state_nxt = RESP;
         RESP: begin
            if (win_vld) begin
               grant     = 1'b1;
               state_nxt = ACCESS;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, grant latches, read data and ready pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         last      <= IDX_W'(CORE_COUNT - 1);
         gnt_idx   <= '0;
         op_r      <= '0;
         addr_r    <= '0;
         wdata_r   <= '0;
         rd_data_r <= '0;
         ready_r   <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            gnt_idx <= win_idx;
            last    <= win_idx;
            op_r    <= enable_M[2*32'(win_idx) +: 2];
            addr_r  <= addr_M[ADDR_SIZE*32'(win_idx) +: ADDR_SIZE];
            wdata_r <= wr_data_M[REG_SIZE*32'(win_idx) +: REG_SIZE];
         end
         if (state == ACCESS && op_r == OP_LD) begin
            rd_data_r <= mem[addr_r];
         end
         ready_r <= '0;
         if (state == ACCESS) begin
            ready_r[gnt_idx] <= 1'b1;
         end
      end
   end

   // Memory write port; reset forces state to IDLE, which blocks a pending store.
   always_ff @(posedge clk) begin
      if (state == ACCESS && op_r == OP_ST) begin
         mem[addr_r] <= wdata_r;
      end
   end

   assign ready_M   = ready_r;
   assign rd_data_M = {CORE_COUNT{rd_data_r}};

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: per-core request queues model the
// cores, expected completions (core, cycle, data) are queued in grant order.
module tb_shared_mem_arbiter;

   localparam int unsigned CORE_COUNT   = 4;
   localparam int unsigned REG_SIZE     = 8;
   localparam int unsigned CORE_ID_SIZE = 2;
   localparam int unsigned ADDR_SIZE    = CORE_ID_SIZE + REG_SIZE;
   localparam logic [1:0]  OP_LD  = 2'b01;
   localparam logic [1:0]  OP_ST  = 2'b10;
   localparam logic [1:0]  OP_BAD = 2'b11;

   typedef struct {
      logic [1:0]           op;
      logic [ADDR_SIZE-1:0] addr;
      logic [REG_SIZE-1:0]  data;
   } req_t;

   typedef struct {
      int                  core;
      logic [REG_SIZE-1:0] data;
      int                  at;
   } exp_t;

   logic                            clk   = 1'b0;
   logic                            reset = 1'b1;
   logic [2*CORE_COUNT-1:0]         enable_M;
   logic [ADDR_SIZE*CORE_COUNT-1:0] addr_M;
   logic [REG_SIZE*CORE_COUNT-1:0]  wr_data_M;
   logic [REG_SIZE*CORE_COUNT-1:0]  rd_data_M;
   logic [CORE_COUNT-1:0]           ready_M;

   req_t                pend [CORE_COUNT][$];
   exp_t                exp_q [$];
   bit                  adv [CORE_COUNT];
   logic [REG_SIZE-1:0] mdl_mem [1 << ADDR_SIZE];
   logic [REG_SIZE-1:0] mdl_rd = '0;
   int                  cyc      = 0;
   int                  n_checks = 0;
   int                  n_fail   = 0;

   shared_mem_arbiter #(
      .CORE_COUNT  (CORE_COUNT),
      .REG_SIZE    (REG_SIZE),
      .CORE_ID_SIZE(CORE_ID_SIZE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable_M (enable_M),
      .addr_M   (addr_M),
      .wr_data_M(wr_data_M),
      .rd_data_M(rd_data_M),
      .ready_M  (ready_M)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic issue(input int core, input logic [1:0] op,
                        input logic [ADDR_SIZE-1:0] addr, input logic [REG_SIZE-1:0] data);
      req_t r;
      r.op   = op;
      r.addr = addr;
      r.data = data;
      pend[core].push_back(r);
   endtask

   // Updates the memory model in predicted grant order and queues the completion.
   task automatic expect_txn(input int core, input logic [1:0] op,
                             input logic [ADDR_SIZE-1:0] addr, input logic [REG_SIZE-1:0] data,
                             input int at);
      exp_t e;
      if (op == OP_LD) mdl_rd = mdl_mem[addr];
      else             mdl_mem[addr] = data;
      e.core = core;
      e.data = mdl_rd;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   function automatic bit busy();
      bit b = (exp_q.size() != 0);
      for (int i = 0; i < CORE_COUNT; i++) if (pend[i].size() != 0) b = 1'b1;
      return b;
   endfunction

   task automatic drain(input int budget);
      int n = 0;
      while (busy() && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy()) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic single(input int core, input logic [1:0] op,
                         input logic [ADDR_SIZE-1:0] addr, input logic [REG_SIZE-1:0] data);
      int t0;
      @(negedge clk);
      t0 = cyc + 1;
      issue(core, op, addr, data);
      expect_txn(core, op, addr, data, t0 + 2);
      drain(20);
   endtask

   // Core model: drive the head request, advance on the edge ending a ready cycle.
   initial begin
      enable_M  = '0;
      addr_M    = '0;
      wr_data_M = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < CORE_COUNT; i++) begin
            if (adv[i]) begin
               if (pend[i].size() > 0) void'(pend[i].pop_front());
               adv[i] = 1'b0;
            end
            if (pend[i].size() > 0) begin
               enable_M[2*i +: 2]                   = pend[i][0].op;
               addr_M[ADDR_SIZE*i +: ADDR_SIZE]     = pend[i][0].addr;
               wr_data_M[REG_SIZE*i +: REG_SIZE]    = pend[i][0].data;
            end else begin
               enable_M[2*i +: 2] = 2'b00;
            end
         end
      end
   end

   // Completion monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ready_M != '0) begin
            check("ready_onehot", 64'($countones(ready_M)), 64'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_ready", 64'(ready_M), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("ready_core", 64'(ready_M), 64'(1 << e.core));
               check("ready_cycle", 64'(cyc), 64'(e.at));
               check("rd_data", 64'(rd_data_M), 64'({CORE_COUNT{e.data}}));
            end
            for (int i = 0; i < CORE_COUNT; i++) if (ready_M[i]) adv[i] = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      int t0;
      #2 reset = 1'b0;

      // Reset state, then core 0 requesting from the first cycle after release.
      issue(0, OP_ST, 10'h000, 8'h11);
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready_M), 64'd0);
      check("rst_rd_data", 64'(rd_data_M), 64'd0);
      reset = 1'b1;
      expect_txn(0, OP_ST, 10'h000, 8'h11, cyc + 2);
      drain(20);

      // Store then load by core 0.
      @(negedge clk);
      t0 = cyc + 1;
      issue(0, OP_ST, 10'h0A5, 8'h3C);
      issue(0, OP_LD, 10'h0A5, 8'h00);
      expect_txn(0, OP_ST, 10'h0A5, 8'h3C, t0 + 2);
      expect_txn(0, OP_LD, 10'h0A5, 8'h00, t0 + 5);
      drain(30);

      // Preload; the last grant goes to core 3 so core 0 has priority next.
      single(0, OP_ST, 10'h040, 8'hD4);
      single(1, OP_ST, 10'h210, 8'hA1);
      single(1, OP_ST, 10'h100, 8'h7E);
      single(2, OP_ST, 10'h320, 8'hB2);
      single(3, OP_ST, 10'h130, 8'hC3);

      // All four cores load in the same cycle.
      @(negedge clk);
      t0 = cyc + 1;
      issue(0, OP_LD, 10'h040, 8'h00);
      issue(1, OP_LD, 10'h210, 8'h00);
      issue(2, OP_LD, 10'h320, 8'h00);
      issue(3, OP_LD, 10'h130, 8'h00);
      expect_txn(0, OP_LD, 10'h040, 8'h00, t0 + 2);
      expect_txn(1, OP_LD, 10'h210, 8'h00, t0 + 4);
      expect_txn(2, OP_LD, 10'h320, 8'h00, t0 + 6);
      expect_txn(3, OP_LD, 10'h130, 8'h00, t0 + 8);
      drain(40);

      // Cores 1 and 3 back-to-back: strict alternation, one access per 2 cycles.
      @(negedge clk);
      t0 = cyc + 1;
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0) issue(1, OP_ST, 10'h050, 8'(8'h10 + k));
         else            issue(1, OP_LD, 10'h050, 8'h00);
         if (k % 2 == 0) issue(3, OP_LD, 10'h130, 8'h00);
         else            issue(3, OP_ST, 10'h130, 8'(8'h30 + k));
      end
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0) expect_txn(1, OP_ST, 10'h050, 8'(8'h10 + k), t0 + 2 + 4*k);
         else            expect_txn(1, OP_LD, 10'h050, 8'h00, t0 + 2 + 4*k);
         if (k % 2 == 0) expect_txn(3, OP_LD, 10'h130, 8'h00, t0 + 4 + 4*k);
         else            expect_txn(3, OP_ST, 10'h130, 8'(8'h30 + k), t0 + 4 + 4*k);
      end
      drain(60);

      // Invalid code 11 is never granted and never writes.
      @(negedge clk);
      issue(2, OP_BAD, 10'h320, 8'hEE);
      repeat (10) @(negedge clk);
      check("bad_code_ready", 64'(ready_M), 64'd0);
      pend[2].delete();
      single(2, OP_LD, 10'h320, 8'h00);

      // Reset during the ACCESS cycle of a store.
      @(negedge clk);
      issue(2, OP_ST, 10'h100, 8'h55);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pend[2].delete();
      #1;
      check("midrst_ready", 64'(ready_M), 64'd0);
      check("midrst_rd_data", 64'(rd_data_M), 64'd0);
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      mdl_rd = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_ready", 64'(ready_M), 64'd0);
         check("post_rst_rd_data", 64'(rd_data_M), 64'd0);
      end
      single(1, OP_LD, 10'h100, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
